serial_logic_unit_16: RTL and testbench
=======================================

Name: serial_logic_unit_16

Overview:
Bit-serial bitwise logic unit. It accepts two WIDTH-bit operands and an opcode through a valid/ready handshake, then computes the result one bit per clock, LSB first. It presents the WIDTH-bit result through an output valid/ready handshake. It is the sequential, handshaked counterpart to the combinational 16-bit gate samples, and gives the lab a multi-cycle datapath with FSM control.

Parameters:
WIDTH, 16, operand/result width in bits; legal range is >= 2.

Ports:
clk  input  1  rising-edge clock, the only clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand set on input1/input2/op is valid.
in_ready  output  1  unit can accept operands; high only in IDLE.
input1  input  WIDTH  operand A.
input2  input  WIDTH  operand B.
op  input  2  operation select: 00 OR, 01 AND, 10 XOR, 11 NOR.
o  output  WIDTH  result; registered.
out_valid  output  1  o holds a completed result.
out_ready  input  1  downstream accepts the result.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- All operations are BITWISE per bit position. Logical (||, &&) semantics are forbidden: 0x00F0 OR 0x0F0F = 0x0FFF, not 0x0001.
- Reset, sampled at posedge clk when reset=1:
  - state=IDLE, count=0, shift registers=0.
  - o=0, out_valid=0, busy=0, in_ready=1.
  - Reset has priority over every other event.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch input1 to regA, input2 to regB, op to opR; clear resR; set count=0; go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT, on each edge:
  - resR <= {f(regA[0], regB[0], opR), resR[WIDTH-1:1]}.
  - regA and regB shift right by 1.
  - count increments.
  - On the edge where count==WIDTH-1: go to DONE and load o <= the final resR value, including this bit.
  - Exactly WIDTH SHIFT cycles occur.
- Latency: if operands are accepted at edge E, out_valid is first high in the cycle after edge E+WIDTH (16 cycles for the default width).
- DONE:
  - out_valid=1 and o is stable.
  - The FSM stays in DONE while out_ready=0 (backpressure has no limit).
  - On an edge with out_ready=1: go to IDLE; out_valid=0 in the next cycle.
- Input sampling outside IDLE:
  - in_ready=0 in SHIFT and DONE; in_valid is ignored there.
  - input1, input2 and op may change freely after acceptance; changes do not affect the result in flight.
- Back-to-back operation: the next acceptance is possible at the first IDLE edge. The minimum initiation interval is WIDTH+2 cycles when out_ready is held at 1.
- o after a transfer: o keeps the last result after the DONE-to-IDLE transition until the next DONE load. Consumers must qualify o with out_valid.
- Reset mid-operation, in SHIFT or DONE: the operation is aborted, the result is discarded, and the reset values above apply on the next cycle.
- Outputs are combinational decodes of the state register only; no input-to-output combinational paths.
- count width: $clog2(WIDTH); it must not wrap before the DONE transition.

Test Plan:
1. op=00, input1=0x00F0, input2=0x0F0F, in_valid pulsed for 1 cycle -> out_valid rises 16 cycles after acceptance, o=0x0FFF (must not be 0x0001).
2. Cover the remaining ops with out_ready=1 held:
   - op=01, 0xFFFF & 0x1234 -> 0x1234.
   - op=10, 0xAAAA ^ 0x5555 -> 0xFFFF.
   - op=11, NOR(0x0000, 0x0000) -> 0xFFFF.
   - In each case out_valid is high for exactly 1 cycle.
3. Backpressure: op=00, 0x8001 | 0x0100, out_ready held 0 for 5 cycles after out_valid -> o=0x8101 stable, out_valid=1, in_ready=0, busy=1 throughout; a new in_valid pulse in this window is ignored; out_ready=1 -> IDLE on the next cycle.
4. Operand change in flight: accept 0x0F0F | 0x0000, then drive input1=0xFFFF and op=01 on the following cycle -> result is still 0x0F0F.
5. Reset mid-operation: accept operands, assert reset for 1 cycle at the 7th SHIFT cycle -> next cycle out_valid=0, o=0, in_ready=1, busy=0; no result is produced afterwards. A fresh op=00, 0x0003 | 0x0004 then gives 0x0007.
6. Back-to-back: in_valid held 1 and out_ready held 1 with three operand sets -> three results in order, acceptances spaced exactly 18 cycles apart, no lost or duplicated results.

Source files
------------

// File: rtl/serial_logic_unit_16.sv
// serial_logic_unit_16
//   Bit-serial bitwise logic unit. Two WIDTH-bit operands and a 2-bit opcode
//   are accepted via a valid/ready handshake. The result is then built one bit
//   per clock, LSB first, over exactly WIDTH cycles. It is offered on an output
//   valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand set on input1/input2/op is valid
//   in_ready   unit can accept operands (IDLE only)
//   input1     operand A
//   input2     operand B
//   op         00 OR, 01 AND, 10 XOR, 11 NOR (bitwise)
//   o          registered result; holds last result until the next completion
//   out_valid  o holds a completed result (DONE)
//   out_ready  downstream accepts the result
//   busy       high in SHIFT or DONE
module serial_logic_unit_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rega_reg, regb_reg, res_reg, o_reg;
  logic [1:0]       op_reg;
  logic [CW-1:0]    count_reg;

  logic             last_shift;
  logic             res_bit;
  logic [WIDTH-1:0] res_word;

  // The final SHIFT edge is the one where the count reaches WIDTH-1.
  assign last_shift = (count_reg == CW'(WIDTH - 1));

  // Per-bit function on the current LSBs of the operand shift registers.
  always_comb begin
    res_bit = 1'b0;
    case (op_reg)
      2'b00:   res_bit = rega_reg[0] | regb_reg[0];
      2'b01:   res_bit = rega_reg[0] & regb_reg[0];
      2'b10:   res_bit = rega_reg[0] ^ regb_reg[0];
      default: res_bit = ~(rega_reg[0] | regb_reg[0]);
    endcase
  end

  // New bit enters at the MSB so that after WIDTH shifts bit 0 is the first
  // computed (LSB) bit.
  assign res_word = {res_bit, res_reg[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rega_reg  <= '0;
      regb_reg  <= '0;
      res_reg   <= '0;
      op_reg    <= 2'b00;
      count_reg <= '0;
      o_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            rega_reg  <= input1;
            regb_reg  <= input2;
            op_reg    <= op;
            res_reg   <= '0;
            count_reg <= '0;
          end
        end
        SHIFT: begin
          res_reg   <= res_word;
          rega_reg  <= {1'b0, rega_reg[WIDTH-1:1]};
          regb_reg  <= {1'b0, regb_reg[WIDTH-1:1]};
          count_reg <= count_reg + CW'(1);
          if (last_shift) begin
            o_reg <= res_word;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the state register only; o is a register.
  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign o         = o_reg;

endmodule

// File: tb/tb_serial_logic_unit_16.sv
// Testbench for serial_logic_unit_16: scoreboard of expected results pushed on
// acceptance and popped on each output transfer, plus latency tracking.
module tb_serial_logic_unit_16;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [1:0]       op;
  logic [WIDTH-1:0] o;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [WIDTH-1:0] sb_q[$];
  int               acc_q[$];
  logic             ov_prev = 1'b0;

  serial_logic_unit_16 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input1    (input1),
    .input2    (input2),
    .op        (op),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [1:0] f);
    case (f)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      acc_q.delete();
    end else begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), WIDTH);
        else chk("spurious_out_valid", 1, 0);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() > 0) begin
          logic [WIDTH-1:0] e;
          e = sb_q.pop_front();
          chk("result", o, e);
          $display("[TB] result o=0x%04h expected=0x%04h", o, e);
        end else begin
          chk("extra_result", 1, 0);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(input1, input2, op));
        acc_q.push_back(cyc + 1);
        $display("[TB] accept op=%0d a=0x%04h b=0x%04h", op, input1, input2);
      end
    end
    ov_prev = out_valid;
  end

  // Drive operands with in_valid until accepted; returns the acceptance edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] f, input bit hold_valid, output int acc);
    bit ok;
    ok = 0;
    acc = 0;
    input1 = a;
    input2 = b;
    op = f;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold_valid) in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) break;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  int acc0, acc1, acc2;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    input1 = '0;
    input2 = '0;
    op = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_o", o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // 1: bitwise OR, not logical
    send(16'h00F0, 16'h0F0F, 2'b00, 0, acc0);
    drain();

    // 2: remaining ops
    send(16'hFFFF, 16'h1234, 2'b01, 0, acc0);
    drain();
    send(16'hAAAA, 16'h5555, 2'b10, 0, acc0);
    drain();
    send(16'h0000, 16'h0000, 2'b11, 0, acc0);
    drain();

    // 3: backpressure
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(16'h8001, 16'h0100, 2'b00, 0, acc0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_o", o, 16'h8101);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      @(posedge clk);
      #1;
      in_valid = (i == 1);
      input1 = 16'h1111;
      input2 = 16'h2222;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_o_hold", o, 16'h8101);

    // 4: operand change in flight
    send(16'h0F0F, 16'h0000, 2'b00, 0, acc0);
    input1 = 16'hFFFF;
    op = 2'b01;
    drain();

    // 5: reset at 7th SHIFT cycle
    send(16'h1234, 16'h4321, 2'b10, 0, acc0);
    while (cyc < acc0 + 6) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_o", o, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (25) @(negedge clk);
    chk("mid_rst_quiet", out_valid, 0);
    send(16'h0003, 16'h0004, 2'b00, 0, acc0);
    drain();

    // 6: back-to-back
    send(16'h1357, 16'h2468, 2'b00, 1, acc0);
    send(16'hF0F0, 16'h3C3C, 2'b01, 1, acc1);
    send(16'hDEAD, 16'hBEEF, 2'b10, 0, acc2);
    chk("b2b_spacing_1", acc1 - acc0, WIDTH + 2);
    chk("b2b_spacing_2", acc2 - acc1, WIDTH + 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
